// File: rtl/frame_sync_deframer.sv
`default_nettype none
// ==========================================================================
// frame_sync_deframer : serial header hunt, multi-frame lock with flywheel,
//                       and payload extraction for the downstream decoder.
// Revision 1.0
// ==========================================================================
module frame_sync_deframer #(
  parameter int                  HEADER_W  = 4,
  parameter logic [HEADER_W-1:0] HEADER    = 4'b0110,
  parameter int                  PAYLOAD_W = 12,
  parameter int                  LOCK_CNT  = 3,
  parameter int                  MISS_CNT  = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [PAYLOAD_W-1:0] r_frame_data,
  output logic                 frame_valid,
  output logic                 frame_correct
);

  localparam int MAX_W = (HEADER_W > PAYLOAD_W) ? HEADER_W : PAYLOAD_W;
  localparam int BC_W  = $clog2(MAX_W);
  localparam int GC_W  = $clog2(LOCK_CNT + 1);
  localparam int MC_W  = $clog2(MISS_CNT + 1);

  localparam logic [BC_W-1:0] HDR_LAST  = BC_W'(HEADER_W - 1);
  localparam logic [BC_W-1:0] PAY_LAST  = BC_W'(PAYLOAD_W - 1);
  localparam logic [GC_W-1:0] GOOD_MAX  = GC_W'(LOCK_CNT);
  localparam logic [MC_W-1:0] MISS_LAST = MC_W'(MISS_CNT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    HDR     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [HEADER_W-1:0]  hdr_sr_q, hdr_sr_d;
  logic [PAYLOAD_W-1:0] pay_sr_q, pay_sr_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GC_W-1:0]      good_cnt_q, good_cnt_d;
  logic [MC_W-1:0]      miss_cnt_q, miss_cnt_d;
  logic [PAYLOAD_W-1:0] frame_data_q, frame_data_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_correct_q, frame_correct_d;

  logic [HEADER_W-1:0]  w_hdr_next;
  logic                 w_match;

  // Match looks at the window including the bit arriving on this edge.
  assign w_hdr_next = {hdr_sr_q[HEADER_W-2:0], bit_in};
  assign w_match    = (w_hdr_next == HEADER);

  always_comb begin
    state_d         = state_q;
    hdr_sr_d        = hdr_sr_q;
    pay_sr_d        = pay_sr_q;
    bit_cnt_d       = bit_cnt_q;
    good_cnt_d      = good_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    frame_data_d    = frame_data_q;
    frame_valid_d   = 1'b0;
    frame_correct_d = frame_correct_q;
    if (bit_valid) begin
      hdr_sr_d = w_hdr_next;
      case (state_q)
        HUNT: begin
          if (w_match) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            good_cnt_d = GC_W'(1);
            miss_cnt_d = '0;
            if (LOCK_CNT == 1) frame_correct_d = 1'b1;
          end
        end
        PAYLOAD: begin
          pay_sr_d = {pay_sr_q[PAYLOAD_W-2:0], bit_in};
          if (bit_cnt_q == PAY_LAST) begin
            state_d   = HDR;
            bit_cnt_d = '0;
            if (frame_correct_q) begin
              frame_data_d  = pay_sr_d;
              frame_valid_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        HDR: begin
          if (bit_cnt_q != HDR_LAST) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = '0;
            if (w_match) begin
              if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + 1'b1;
              miss_cnt_d = '0;
              state_d    = PAYLOAD;
              if (good_cnt_d == GOOD_MAX) frame_correct_d = 1'b1;
            end else if (frame_correct_q) begin
              // Flywheel: tolerate isolated bad headers until the miss budget runs out.
              if (miss_cnt_q == MISS_LAST) begin
                frame_correct_d = 1'b0;
                good_cnt_d      = '0;
                miss_cnt_d      = '0;
                state_d         = HUNT;
              end else begin
                miss_cnt_d = miss_cnt_q + 1'b1;
                state_d    = PAYLOAD;
              end
            end else begin
              good_cnt_d = '0;
              state_d    = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q         <= HUNT;
      hdr_sr_q        <= '0;
      pay_sr_q        <= '0;
      bit_cnt_q       <= '0;
      good_cnt_q      <= '0;
      miss_cnt_q      <= '0;
      frame_data_q    <= '0;
      frame_valid_q   <= 1'b0;
      frame_correct_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hdr_sr_q        <= hdr_sr_d;
      pay_sr_q        <= pay_sr_d;
      bit_cnt_q       <= bit_cnt_d;
      good_cnt_q      <= good_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      frame_data_q    <= frame_data_d;
      frame_valid_q   <= frame_valid_d;
      frame_correct_q <= frame_correct_d;
    end
  end

  assign r_frame_data  = frame_data_q;
  assign frame_valid   = frame_valid_q;
  assign frame_correct = frame_correct_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_deframer.sv
`default_nettype none
// ==========================================================================
// tb_frame_sync_deframer : randomized self-checking bench with a bit-level
//                          behavioural reference model.
// Revision 1.0
// ==========================================================================
module tb_frame_sync_deframer;

  localparam int HEADER_W  = 4;
  localparam int PAYLOAD_W = 12;
  localparam int LOCK_CNT  = 3;
  localparam int MISS_CNT  = 2;
  localparam int HDR_VAL   = 6;
  localparam int BAD_HDR   = 7;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b1;
  logic                 bit_valid = 1'b0;
  logic                 bit_in = 1'b0;
  logic [PAYLOAD_W-1:0] r_frame_data;
  logic                 frame_valid;
  logic                 frame_correct;

  frame_sync_deframer #(
    .HEADER_W (HEADER_W),
    .HEADER   (4'b0110),
    .PAYLOAD_W(PAYLOAD_W),
    .LOCK_CNT (LOCK_CNT),
    .MISS_CNT (MISS_CNT)
  ) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .r_frame_data (r_frame_data),
    .frame_valid  (frame_valid),
    .frame_correct(frame_correct)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_pass  = 0;

  bit stream[$];
  int got_frames[$];
  int exp_frames[$];

  // Reference model state: frame position counted in bits since the header hit.
  bit m_hunt;
  int m_win, m_pos, m_good, m_miss, m_pay, m_data;
  bit m_lock, m_valid;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_hunt = 1'b1; m_win = 0; m_pos = 0; m_good = 0; m_miss = 0;
    m_pay = 0; m_data = 0; m_lock = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_bit(input bit b);
    m_valid = 1'b0;
    m_win   = (m_win * 2 + int'(b)) % (1 << HEADER_W);
    if (m_hunt) begin
      if (m_win == HDR_VAL) begin
        m_hunt = 1'b0; m_pos = 0; m_good = 1; m_miss = 0;
        if (LOCK_CNT == 1) m_lock = 1'b1;
      end
    end else if (m_pos < PAYLOAD_W) begin
      m_pay = (m_pay * 2 + int'(b)) % (1 << PAYLOAD_W);
      m_pos++;
      if (m_pos == PAYLOAD_W && m_lock) begin
        m_data  = m_pay;
        m_valid = 1'b1;
      end
    end else begin
      m_pos++;
      if (m_pos == PAYLOAD_W + HEADER_W) begin
        m_pos = 0;
        if (m_win == HDR_VAL) begin
          m_good = (m_good < LOCK_CNT) ? m_good + 1 : LOCK_CNT;
          m_miss = 0;
          if (m_good >= LOCK_CNT) m_lock = 1'b1;
        end else if (m_lock) begin
          m_miss++;
          if (m_miss >= MISS_CNT) begin
            m_lock = 1'b0; m_good = 0; m_miss = 0; m_hunt = 1'b1;
          end
        end else begin
          m_good = 0; m_hunt = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"},   int'(frame_valid),   int'(m_valid));
    check({tag, "_correct"}, int'(frame_correct), int'(m_lock));
    check({tag, "_data"},    int'(r_frame_data),  m_data);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit v, input bit b);
    bit_valid = v;
    bit_in    = b;
    @(posedge sys_clk);
    if (v) model_bit(b);
    else   m_valid = 1'b0;
    @(negedge sys_clk);
    check_outputs("cyc");
    if (frame_valid) got_frames.push_back(int'(r_frame_data));
  endtask

  task automatic apply_reset(input int cycles);
    #2 sys_rst = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_now");
    repeat (cycles) begin
      bit_valid = 1'($urandom_range(1, 0));
      bit_in    = 1'($urandom_range(1, 0));
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_outputs("rst_hold");
    end
    sys_rst = 1'b1;
  endtask

  task automatic push_field(input int val, input int w);
    for (int i = w - 1; i >= 0; i--) stream.push_back(1'((val >> i) & 1));
  endtask

  task automatic push_frame(input int hdr, input int pay);
    push_field(hdr, HEADER_W);
    push_field(pay, PAYLOAD_W);
  endtask

  task automatic push_clean_lock();
    push_frame(HDR_VAL, 'hABC);
    push_frame(HDR_VAL, 'h123);
    push_frame(HDR_VAL, 'h456);
    push_frame(HDR_VAL, 'h789);
  endtask

  // mode 0: valid every 4th clock; 1: gaps of 1-7; other: gaps of 0-2.
  task automatic send_stream(input int mode);
    foreach (stream[i]) begin
      int gap;
      case (mode)
        0:       gap = 3;
        1:       gap = $urandom_range(7, 1);
        default: gap = $urandom_range(2, 0);
      endcase
      repeat (gap) step(1'b0, 1'($urandom_range(1, 0)));
      step(1'b1, stream[i]);
    end
    stream.delete();
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, got_frames.size(), exp_frames.size());
    foreach (exp_frames[i])
      if (i < got_frames.size()) check(tag, got_frames[i], exp_frames[i]);
    got_frames.delete();
    exp_frames.delete();
  endtask

  initial begin
    model_reset();
    @(negedge sys_clk);

    apply_reset(2);

    push_clean_lock();
    send_stream(0);
    exp_frames = '{'h456, 'h789};
    check_frames("clean");
    check("clean_locked", int'(frame_correct), 1);

    push_frame(BAD_HDR, 'h5A5);
    push_frame(HDR_VAL, 'h321);
    push_frame(BAD_HDR, 'hAAA);
    push_frame(BAD_HDR, 'hBBB);
    send_stream(0);
    exp_frames = '{'h5A5, 'h321, 'hAAA};
    check_frames("flywheel");
    check("flywheel_dropped", int'(frame_correct), 0);

    apply_reset(2);
    push_field('b1110001, 7);
    push_clean_lock();
    send_stream(0);
    exp_frames = '{'h456, 'h789};
    check_frames("prefix");

    push_frame(HDR_VAL, 'hCDE >> 7);
    stream = stream[0:HEADER_W+4];
    send_stream(0);
    check("mid_locked", int'(frame_correct), 1);
    got_frames.delete();
    apply_reset(2);
    push_frame(HDR_VAL, 'h111);
    push_frame(HDR_VAL, 'h222);
    push_frame(HDR_VAL, 'h333);
    send_stream(0);
    exp_frames = '{'h333};
    check_frames("relock");

    apply_reset(1);
    push_clean_lock();
    send_stream(1);
    exp_frames = '{'h456, 'h789};
    check_frames("irregular");
    check("irregular_locked", int'(frame_correct), 1);

    apply_reset(1);
    for (int f = 0; f < 60; f++) begin
      int hdr;
      hdr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : HDR_VAL;
      push_frame(hdr, int'($urandom_range(4095, 0)));
      if ($urandom_range(9, 0) == 0) stream.push_back(1'($urandom_range(1, 0)));
    end
    send_stream(2);
    got_frames.delete();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
